// File: rtl/top_digitalclock.sv
// 24-hour HH:MM:SS clock: a prescaler produces a 1 Hz tick that advances six BCD digits driving active-low 7-segment outputs.
// Optional LEADING_ZERO_BLANK_EN blanks the hours tens display when that digit is 0.
module top_digitalclock #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [6:0] seg_s10,
  output logic [6:0] seg_s1,
  output logic [6:0] seg_m10,
  output logic [6:0] seg_m1,
  output logic [6:0] seg_h10,
  output logic [6:0] seg_h1
);

  localparam int PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);

  logic [PW-1:0] presc;
  logic [3:0]    s1, s10, m1, m10, h1, h10;
  logic          tick;

  // Tick only fires in an enabled wrap cycle, so dropping enable there simply postpones it.
  assign tick = enable && (presc == PRESC_LAST);

  // NOTE: every register below is assigned with <= so all carries see the pre-edge digit values.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      s1    <= '0;
      s10   <= '0;
      m1    <= '0;
      m10   <= '0;
      h1    <= '0;
      h10   <= '0;
    end else if (enable) begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        if (s1 != 4'd9) begin
          s1 <= s1 + 4'd1;
        end else begin
          s1 <= 4'd0;
          if (s10 != 4'd5) begin
            s10 <= s10 + 4'd1;
          end else begin
            s10 <= 4'd0;
            if (m1 != 4'd9) begin
              m1 <= m1 + 4'd1;
            end else begin
              m1 <= 4'd0;
              if (m10 != 4'd5) begin
                m10 <= m10 + 4'd1;
              end else begin
                m10 <= 4'd0;
                if (h10 == 4'd2 && h1 == 4'd3) begin
                  h10 <= 4'd0;
                  h1  <= 4'd0;
                end else if (h1 == 4'd9) begin
                  h1  <= 4'd0;
                  h10 <= h10 + 4'd1;
                end else begin
                  h1  <= h1 + 4'd1;
                end
              end
            end
          end
        end
      end
    end
  end

  // Segment order {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    // NOTE: the default arm gives every input a value, so no latch is inferred.
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign seg_s1  = seg7(s1);
  assign seg_s10 = seg7(s10);
  assign seg_m1  = seg7(m1);
  assign seg_m10 = seg7(m10);
  assign seg_h1  = seg7(h1);
`ifdef LEADING_ZERO_BLANK_EN
  assign seg_h10 = (h10 == 4'd0) ? 7'h7F : seg7(h10);
`else
  assign seg_h10 = seg7(h10);
`endif

endmodule

// File: tb/tb_top_digitalclock.sv
// Directed self-checking bench for top_digitalclock with CLK_FREQ=4.
// Long hour/day carries are reached by depositing digit values, since running 86399 ticks would take too long.
module tb_top_digitalclock;

  localparam int CF = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] H10_ZERO = 7'h7F;
`else
  localparam logic [6:0] H10_ZERO = 7'h40;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [6:0] seg_s10, seg_s1, seg_m10, seg_m1, seg_h10, seg_h1;
  logic [41:0] disp;

  int n_checks = 0;
  int n_fail   = 0;

  top_digitalclock #(.CLK_FREQ(CF)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .seg_s10 (seg_s10),
    .seg_s1  (seg_s1),
    .seg_m10 (seg_m10),
    .seg_m1  (seg_m1),
    .seg_h10 (seg_h10),
    .seg_h1  (seg_h1)
  );

  always #5 clk = ~clk;

  assign disp = {seg_h10, seg_h1, seg_m10, seg_m1, seg_s10, seg_s1};

  // Advance n rising edges, then settle at the following falling edge for sampling.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enable = 1'b0;
    cycles(3);
    n_checks++;
    if (disp !== {H10_ZERO, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}) begin
      n_fail++;
      $display("FAIL reset_all: got %h want %h", disp, {H10_ZERO, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
    end
    // enable has no effect while reset is held
    enable = 1'b1;
    cycles(5);
    n_checks++;
    if (disp !== {H10_ZERO, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}) begin
      n_fail++;
      $display("FAIL reset_overrides_enable: got %h want %h", disp, {H10_ZERO, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
    end
  endtask

  task automatic test_seconds_roll;
    rst = 1'b0;
    enable = 1'b1;
    cycles(3);
    n_checks++;
    if (seg_s1 !== 7'h40) begin
      n_fail++;
      $display("FAIL s1_before_first_tick: got %h want 40", seg_s1);
    end
    cycles(1);
    n_checks++;
    if (seg_s1 !== 7'h79) begin
      n_fail++;
      $display("FAIL s1_first_tick: got %h want 79", seg_s1);
    end
    cycles(35);  // 39 cycles: 00:00:09
    n_checks++;
    if (disp !== {H10_ZERO, 7'h40, 7'h40, 7'h40, 7'h40, 7'h10}) begin
      n_fail++;
      $display("FAIL at_00_00_09: got %h want %h", disp, {H10_ZERO, 7'h40, 7'h40, 7'h40, 7'h40, 7'h10});
    end
    cycles(1);   // 40 cycles: 00:00:10
    n_checks++;
    if (disp !== {H10_ZERO, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40}) begin
      n_fail++;
      $display("FAIL at_00_00_10: got %h want %h", disp, {H10_ZERO, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40});
    end
  endtask

  task automatic test_full_carry;
    // From 00:00:10 to 00:59:59 is 3589 ticks.
    cycles(CF * 3589);
    n_checks++;
    if (disp !== {H10_ZERO, 7'h40, 7'h12, 7'h10, 7'h12, 7'h10}) begin
      n_fail++;
      $display("FAIL at_00_59_59: got %h want %h", disp, {H10_ZERO, 7'h40, 7'h12, 7'h10, 7'h12, 7'h10});
    end
    cycles(CF);
    n_checks++;
    if (disp !== {H10_ZERO, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40}) begin
      n_fail++;
      $display("FAIL at_01_00_00: got %h want %h", disp, {H10_ZERO, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40});
    end
  endtask

  task automatic test_enable_hold;
    cycles(2);          // prescaler now at 2
    enable = 1'b0;
    cycles(100);
    n_checks++;
    if (disp !== {H10_ZERO, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40}) begin
      n_fail++;
      $display("FAIL hold_100: got %h want %h", disp, {H10_ZERO, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40});
    end
    enable = 1'b1;
    cycles(1);
    n_checks++;
    if (seg_s1 !== 7'h40) begin
      n_fail++;
      $display("FAIL resume_no_early_tick: got %h want 40", seg_s1);
    end
    cycles(1);
    n_checks++;
    if (seg_s1 !== 7'h79) begin
      n_fail++;
      $display("FAIL resume_remaining_cycles: got %h want 79", seg_s1);
    end
    // Drop enable while the prescaler sits at its wrap value.
    cycles(3);
    enable = 1'b0;
    cycles(5);
    n_checks++;
    if (seg_s1 !== 7'h79) begin
      n_fail++;
      $display("FAIL hold_in_wrap_cycle: got %h want 79", seg_s1);
    end
    enable = 1'b1;
    cycles(1);
    n_checks++;
    if (disp !== {H10_ZERO, 7'h79, 7'h40, 7'h40, 7'h40, 7'h24}) begin
      n_fail++;
      $display("FAIL tick_after_wrap_hold: got %h want %h", disp, {H10_ZERO, 7'h79, 7'h40, 7'h40, 7'h40, 7'h24});
    end
  endtask

  task automatic test_reset_mid_run;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(CF * 7);
    n_checks++;
    if (disp !== {H10_ZERO, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78}) begin
      n_fail++;
      $display("FAIL at_00_00_07: got %h want %h", disp, {H10_ZERO, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78});
    end
    cycles(2);          // partial second in progress
    rst = 1'b1;
    cycles(1);
    n_checks++;
    if (disp !== {H10_ZERO, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}) begin
      n_fail++;
      $display("FAIL reset_mid_run: got %h want %h", disp, {H10_ZERO, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
    end
    rst = 1'b0;
    cycles(CF - 1);
    n_checks++;
    if (seg_s1 !== 7'h40) begin
      n_fail++;
      $display("FAIL partial_second_discarded: got %h want 40", seg_s1);
    end
    cycles(1);
    n_checks++;
    if (seg_s1 !== 7'h79) begin
      n_fail++;
      $display("FAIL first_tick_after_reset: got %h want 79", seg_s1);
    end
  endtask

  // Prescaler is at 0 on entry; deposit a time, then run one full second.
  task automatic load_time(input logic [3:0] h10, h1, m10, m1, s10, s1);
    enable = 1'b0;
    force dut.h10 = h10;
    force dut.h1  = h1;
    force dut.m10 = m10;
    force dut.m1  = m1;
    force dut.s10 = s10;
    force dut.s1  = s1;
    #1;
    release dut.h10;
    release dut.h1;
    release dut.m10;
    release dut.m1;
    release dut.s10;
    release dut.s1;
    #1;
  endtask

  task automatic test_ripple;
    load_time(4'd0, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9);
    enable = 1'b1;
    cycles(CF);
    n_checks++;
    if (disp !== {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}) begin
      n_fail++;
      $display("FAIL ripple_09_to_10: got %h want %h", disp, {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
    end
  endtask

  task automatic test_day_wrap;
    load_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9);
    n_checks++;
    if (disp !== {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10}) begin
      n_fail++;
      $display("FAIL at_23_59_59: got %h want %h", disp, {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10});
    end
    enable = 1'b1;
    cycles(CF - 1);
    n_checks++;
    if (disp !== {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10}) begin
      n_fail++;
      $display("FAIL hold_before_day_wrap: got %h want %h", disp, {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10});
    end
    cycles(1);
    n_checks++;
    if (disp !== {H10_ZERO, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}) begin
      n_fail++;
      $display("FAIL day_wrap: got %h want %h", disp, {H10_ZERO, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
    end
    // 19:59:59 -> 20:00:00 must not take the 23 wrap path
    load_time(4'd1, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9);
    enable = 1'b1;
    cycles(CF);
    n_checks++;
    if (disp !== {7'h24, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}) begin
      n_fail++;
      $display("FAIL ripple_19_to_20: got %h want %h", disp, {7'h24, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_seconds_roll;
    test_full_carry;
    test_enable_hold;
    test_reset_mid_run;
    test_ripple;
    test_day_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/top_digitalclock.md
# top_digitalclock

24-hour digital clock (HH:MM:SS) for the FPGA board top level. A prescaler divides the 50 MHz system clock to a 1 Hz tick. The tick advances six BCD digit counters, and each digit drives one 7-segment display. Counting can be paused with `enable`.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: system clock cycles per one-second tick. Must be ≥ 2; benches use small values.

Ports:
- `clk`  in  1  system clock, 50 MHz (20 ns period), rising-edge.
- `rst`  in  1  reset; synchronous and active-high.
- `enable`  in  1  count enable; 1 = run, 0 = hold time and prescaler.
- `seg_s10`  out  7  seconds tens digit (0–5).
- `seg_s1`  out  7  seconds ones digit (0–9).
- `seg_m10`  out  7  minutes tens digit (0–5).
- `seg_m1`  out  7  minutes ones digit (0–9).
- `seg_h10`  out  7  hours tens digit (0–2).
- `seg_h1`  out  7  hours ones digit (0–9).

Segment bit order is {g,f,e,d,c,b,a}, active-low (0 = lit).

## Operation
- Prescaler:
  - Counter `0..CLK_FREQ-1`, width `$clog2(CLK_FREQ)`.
  - It increments only while `enable`=1.
  - It wraps to 0 at `CLK_FREQ-1`; that cycle asserts the internal `tick`.
- On `tick`, the BCD counters advance by one second:
  - `s1` 9→0 carries into `s10`.
  - `s10` 5→0 (at 59 s) carries into `m1`.
  - `m1` 9→0 carries into `m10`.
  - `m10` 5→0 (at 59 min) carries into the hours.
  - Hours count 00..23. At 23 they wrap to 00: `h10`=2 and `h1`=3 → both 0. Otherwise `h1` 9→0 carries into `h10`.
  - Time 23:59:59 + tick → 00:00:00.
- `enable`=0: prescaler and all digits hold their values. They are not cleared. Counting resumes from where it stopped.
- The decoder is combinational from the digit registers:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Any non-BCD value → 7'h7F (blank). Non-BCD values are unreachable in normal operation.
- Reset clears the prescaler and all six digits to 0. Reset overrides `enable` and `tick` in the same cycle.

## Timing
- Reset is synchronous: the state is cleared at the first rising `clk` edge with `rst`=1.
- While `rst`=1, every output equals 7'h40 (displays 00:00:00).
- Reset asserted mid-count discards the partial second. The first tick after release comes `CLK_FREQ` enabled cycles after the first enabled edge.
- Tick latency: with continuous `enable`, the digits change at the edge that ends the `CLK_FREQ`-th enabled cycle after reset release. The segment outputs change in that same cycle (decoder adds no latency).
- All carries ripple within that single edge. 09:59:59 → 10:00:00 happens in one clock.
- Exactly one second advance occurs per tick. There are no double increments.
- `enable` dropping in the wrap cycle: no tick, prescaler holds at `CLK_FREQ-1`. The tick fires on the first enabled cycle afterwards.

## Configuration
- `LEADING_ZERO_BLANK_EN`
  - Defined: `seg_h10` outputs 7'h7F (blank) whenever the hours tens digit is 0. Example: 09:xx shows " 9:xx".
  - Undefined: `seg_h10` always shows the digit, so 0 shows as 7'h40.
  - No other output is affected, and internal counting is identical either way.

## Test plan
- Reset: `CLK_FREQ`=4, hold `rst`=1 for 3 cycles → all six outputs = 7'h40. Undefined macro assumed.
- Seconds roll: `CLK_FREQ`=4, `enable`=1 after reset. After 4 cycles `seg_s1`=7'h79 (1). After 40 cycles `seg_s10`=7'h79 and `seg_s1`=7'h40.
- Full carry: run 3600 ticks → `seg_h1`=7'h79 (1); minutes and seconds outputs = 7'h40.
- Day wrap: run 86399 ticks → displays 23:59:59 (h10=7'h24, h1=7'h30, others 7'h12/7'h10). One more tick → all 7'h40.
- Enable hold: deassert `enable` for 100 cycles mid-second → outputs unchanged. After reassertion, the next tick needs only the remaining prescaler cycles.
- Reset mid-operation at 00:00:07 → next edge all outputs 7'h40. With `LEADING_ZERO_BLANK_EN` defined, `seg_h10`=7'h7F.
